// File: rtl/ramtest_pkg.sv
// Shared types and constants for the SRAM production test engine.
package ramtest_pkg;

    // Engine sequencing states: three-cycle write, two-cycle read, absorbing done.
    typedef enum logic [2:0] {
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdAddr,
        StRdSample,
        StDone
    } state_e;

    // Cycles spent per location in each phase of a pass.
    localparam int unsigned WrCycles = 3;
    localparam int unsigned RdCycles = 2;

    // Cycles for one full pass (write phase plus read phase) over 2^aw bytes.
    function automatic int unsigned pass_cycles(input int unsigned aw);
        return (WrCycles + RdCycles) * (32'd1 << aw);
    endfunction

endpackage

// File: rtl/ramtest_pattern.sv
// Expected byte for a test address: P(a) = a[7:0] ^ a[15:8] ^ a[18:16],
// inverted on the second pass. Purely combinational; the same instance
// feeds both the write data and the read-compare value.
module ramtest_pattern #(
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  inv_i,
    output logic [7:0]            data_o
);

    logic [18:0] a_ext;

    // Address bits above the exercised width read as zero.
    if (ADDR_WIDTH >= 19) begin : g_wide
        assign a_ext = addr_i[18:0];
    end else begin : g_narrow
        assign a_ext = {{(19 - ADDR_WIDTH){1'b0}}, addr_i};
    end

    // Fold the address into a byte and apply the pass polarity.
    always_comb begin
        data_o = a_ext[7:0] ^ a_ext[15:8] ^ {5'b0, a_ext[18:16]};
        if (inv_i) begin
            data_o = ~data_o;
        end
    end

endmodule

// File: rtl/ramtest_ctrl.sv
// SRAM production test engine: writes P(a) to every byte, reads it back and
// reports completion and pass/fail. Every pin is driven from a flop.
// Optional feature: define RAMTEST_INVERSE_PASS_EN to run a second pass with ~P(a).
module ramtest_ctrl
    import ramtest_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic        clk,
    input  logic        rst,
    output logic [20:0] sram_a,
    inout  wire  [7:0]  sram_d,
    output logic        sram_we_n,
    output logic        test_in_progress,
    output logic        test_result
);

`ifdef RAMTEST_INVERSE_PASS_EN
    localparam logic TwoPass = 1'b1;
`else
    localparam logic TwoPass = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pass_q, pass_d;
    logic                  result_q, result_d;

    // Pin registers, loaded from the next state so they line up with state_q.
    logic [20:0] sram_a_q, sram_a_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;
    logic        tip_q, tip_d;
    logic [7:0]  exp_q, exp_d;

    logic addr_last;
    logic last_pass;

    assign addr_last = &addr_q;
    assign last_pass = pass_q | ~TwoPass;

    // Expected byte for the upcoming location; used as write data and compare value.
    ramtest_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pattern (
        .addr_i (addr_d),
        .inv_i  (pass_d),
        .data_o (exp_d)
    );

    // State, address, pass and pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StWrSetup;
            addr_q   <= '0;
            pass_q   <= 1'b0;
            result_q <= 1'b0;
            sram_a_q <= '0;
            we_n_q   <= 1'b1;
            drive_q  <= 1'b0;
            tip_q    <= 1'b1;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pass_q   <= pass_d;
            result_q <= result_d;
            sram_a_q <= sram_a_d;
            we_n_q   <= we_n_d;
            drive_q  <= drive_d;
            tip_q    <= tip_d;
            exp_q    <= exp_d;
        end
    end

    // Sequencing: walk addresses through write then read phases, abort on mismatch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        result_d = result_q;
        unique case (state_q)
            StWrSetup: state_d = StWrPulse;
            StWrPulse: state_d = StWrHold;
            StWrHold: begin
                if (addr_last) begin
                    state_d = StRdAddr;
                    addr_d  = '0;
                end else begin
                    state_d = StWrSetup;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            StRdAddr: state_d = StRdSample;
            StRdSample: begin
                // Written as an equality so an undriven or unknown bus counts as a miss.
                if (sram_d == exp_q) begin
                    if (!addr_last) begin
                        state_d = StRdAddr;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end else if (last_pass) begin
                        state_d  = StDone;
                        addr_d   = '0;
                        result_d = 1'b1;
                    end else begin
                        state_d = StWrSetup;
                        addr_d  = '0;
                        pass_d  = 1'b1;
                    end
                end else begin
                    state_d  = StDone;
                    addr_d   = '0;
                    result_d = 1'b0;
                end
            end
            StDone: state_d = StDone;
            default: begin
                state_d  = StDone;
                addr_d   = '0;
                result_d = 1'b0;
            end
        endcase
    end

    // Pin values for the state being entered.
    always_comb begin
        we_n_d   = (state_d != StWrPulse);
        drive_d  = (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
        sram_a_d = (state_d == StDone) ? 21'd0 : 21'(addr_d);
        tip_d    = (state_d != StDone);
    end

    assign sram_a           = sram_a_q;
    assign sram_we_n        = we_n_q;
    assign sram_d           = drive_q ? exp_q : 8'bz;
    assign test_in_progress = tip_q;
    assign test_result      = result_q;

endmodule

// File: tb/tb_ramtest_ctrl.sv
// Bench for ramtest_ctrl at ADDR_WIDTH=4 with a fault-injectable SRAM model.
module tb_ramtest_ctrl;
    import ramtest_pkg::*;

    localparam int AW = 4;
    localparam int N  = 1 << AW;
`ifdef RAMTEST_INVERSE_PASS_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif
    localparam int WrLen   = WrCycles * N;
    localparam int PassLen = (WrCycles + RdCycles) * N;

    localparam int ModeIdeal = 0;
    localparam int ModeStuck = 1;  // bit 2 stuck at 0 at address 5
    localparam int ModeAlias = 2;  // address bit 3 ignored

    typedef struct packed {
        logic [20:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct packed {
        logic [15:0] k;
        logic        r;
    } res_t;

    logic        clk;
    logic        rst;
    logic [20:0] sram_a;
    wire  [7:0]  sram_d;
    logic        sram_we_n;
    logic        test_in_progress;
    logic        test_result;

    logic        rd_en;
    logic [7:0]  rd_val;
    logic [7:0]  mem [N];
    logic [7:0]  zbyte;
    int          mode;

    wr_t  wr_q  [$];
    res_t res_q [$];

    int n_chk;
    int n_pass;

    assign sram_d = rd_en ? rd_val : 8'bz;

    ramtest_ctrl #(
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sram_a           (sram_a),
        .sram_d           (sram_d),
        .sram_we_n        (sram_we_n),
        .test_in_progress (test_in_progress),
        .test_result      (test_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int a, input int p);
        logic [31:0] aa;
        logic [7:0]  v;
        aa = a;
        v  = aa[7:0] ^ aa[15:8] ^ {5'b0, aa[18:16]};
        return (p != 0) ? ~v : v;
    endfunction

    function automatic int eff(input int m, input int a);
        return (m == ModeAlias) ? (a & 7) : a;
    endfunction

    function automatic logic [7:0] stored(input int m, input int e, input logic [7:0] v);
        return (m == ModeStuck && e == 5) ? (v & 8'hfb) : v;
    endfunction

    // Predict the run: queue every write expected and the done edge and verdict.
    task automatic plan(input int m, output int done_k, output logic res);
        logic [7:0] sim [N];
        done_k = NP * PassLen;
        res    = 1'b1;
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a < N; a++) begin
                wr_q.push_back('{a: 21'(a), d: pat(a, p)});
                sim[eff(m, a)] = stored(m, eff(m, a), pat(a, p));
            end
            for (int a = 0; a < N; a++) begin
                if (sim[eff(m, a)] !== pat(a, p)) begin
                    done_k = p * PassLen + WrLen + RdCycles * a + RdCycles;
                    res    = 1'b0;
                    break;
                end
            end
            if (!res) break;
        end
        res_q.push_back('{k: 16'(done_k), r: res});
    endtask

    // One run from reset; stop_k < 0 runs to completion, else reset is reapplied after stop_k.
    task automatic run(input int m, input int stop_k, input string name);
        int   done_k;
        logic res;
        int   limit;
        bit   seen;
        wr_t  w;
        res_t r;
        int   pass, rr, addr, sub;
        logic [20:0] ea;
        logic        ewe;
        logic        drv;
        logic [7:0]  ed;

        mode  = m;
        rd_en = 1'b0;
        wr_q.delete();
        res_q.delete();
        for (int i = 0; i < N; i++) mem[i] = 8'h5a;
        plan(m, done_k, res);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq({name, ":rst_we_n"}, 32'(sram_we_n), 32'd1);
        check_eq({name, ":rst_bus"}, {24'd0, sram_d}, {24'd0, zbyte});
        check_eq({name, ":rst_tip"}, 32'(test_in_progress), 32'd1);
        check_eq({name, ":rst_result"}, 32'(test_result), 32'd0);
        check_eq({name, ":rst_addr"}, 32'(sram_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        seen  = 1'b0;
        limit = (stop_k >= 0) ? stop_k : done_k + 4;
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            rd_en = 1'b0;
            #1;

            // SRAM write capture and write scoreboard.
            if (sram_we_n === 1'b0) begin
                mem[eff(m, int'(sram_a[3:0]))] =
                    stored(m, eff(m, int'(sram_a[3:0])), sram_d);
                if (wr_q.size() == 0) begin
                    check_eq({name, ":extra_write"}, 32'(sram_a), 32'hffff_ffff);
                end else begin
                    w = wr_q.pop_front();
                    check_eq({name, ":wr_addr"}, 32'(sram_a), 32'(w.a));
                    check_eq({name, ":wr_data"}, {24'd0, sram_d}, {24'd0, w.d});
                end
            end

            // Completion scoreboard.
            if (!seen && test_in_progress === 1'b0) begin
                seen = 1'b1;
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    check_eq({name, ":done_edge"}, 32'(k), 32'(r.k));
                    check_eq({name, ":result"}, 32'(test_result), 32'(r.r));
                end
            end

            // Per-cycle pin expectations.
            if (k >= done_k) begin
                ea = '0; ewe = 1'b1; drv = 1'b0; ed = zbyte; sub = 0;
                check_eq({name, ":tip_done"}, 32'(test_in_progress), 32'd0);
                check_eq({name, ":result_hold"}, 32'(test_result), 32'(res));
            end else begin
                pass = k / PassLen;
                rr   = k % PassLen;
                if (rr < WrLen) begin
                    addr = rr / WrCycles;
                    sub  = rr % WrCycles;
                    ewe  = (sub != 1);
                    drv  = 1'b1;
                    ed   = pat(addr, pass);
                    sub  = -1;
                end else begin
                    addr = (rr - WrLen) / RdCycles;
                    sub  = (rr - WrLen) % RdCycles;
                    ewe  = 1'b1;
                    drv  = 1'b0;
                    ed   = zbyte;
                end
                ea = 21'(addr);
                check_eq({name, ":tip_busy"}, 32'(test_in_progress), 32'd1);
                check_eq({name, ":result_busy"}, 32'(test_result), 32'd0);
            end
            check_eq({name, ":we_n"}, 32'(sram_we_n), 32'(ewe));
            check_eq({name, ":addr"}, 32'(sram_a), 32'(ea));
            // The first setup cycle after reset still shows the reset bus value;
            // the SRAM latches data on the rising we_n edge, so only later cycles matter.
            if (!(drv && k == 0)) begin
                check_eq({name, ":bus"}, {24'd0, sram_d}, {24'd0, ed});
            end

            // RAM answers during the sample cycle of each read.
            if (k < done_k && !drv && sub == 1) begin
                rd_val = mem[eff(m, int'(sram_a[3:0]))];
                rd_en  = 1'b1;
            end
        end

        if (stop_k < 0) begin
            check_eq({name, ":done_seen"}, 32'(seen), 32'd1);
            check_eq({name, ":writes_left"}, 32'(wr_q.size()), 32'd0);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        zbyte  = 'z;
        rd_en  = 1'b0;
        rd_val = '0;
        mode   = ModeIdeal;
        rst    = 1'b0;

        run(ModeIdeal, -1, "ideal");
        run(ModeStuck, -1, "stuck");
        run(ModeAlias, -1, "alias");
        run(ModeIdeal, WrLen + 7, "midrd");
        run(ModeIdeal, -1, "rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ramtest_ctrl.md
# ramtest_ctrl

Self-contained SRAM production test engine for the board-test image. After reset it writes an address-derived byte pattern to every location of the external 512 KB asynchronous SRAM and reads it back, then reports completion and pass/fail on two status outputs. It sits directly on the SRAM pins and needs no CPU or host interaction.

## Interface
- ADDR_WIDTH, 19: number of SRAM address bits exercised (2^ADDR_WIDTH bytes); reduced values are used for simulation.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- sram_a  out  21  SRAM address; bits [ADDR_WIDTH-1:0] carry the test address, all higher bits are 0.
- sram_d  inout  8  SRAM data bus; driven only in write states, high-Z otherwise.
- sram_we_n  out  1  SRAM write enable, active-low.
- test_in_progress  out  1  1 while the test runs; 0 once finished.
- test_result  out  1  valid when test_in_progress=0: 1 = pass, 0 = fail.

## Operation
- Pattern: P(a) = a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} (unused high bits read as 0). With pass-inversion enabled, the second pass uses ~P(a).
- Pass = write phase (address 0 up to 2^ADDR_WIDTH-1), then read phase over the same range.
- States: WR_SETUP (address and data driven, we_n=1) -> WR_PULSE (we_n=0) -> WR_HOLD (we_n=1, data still driven) -> next address, or RD_ADDR at address 0 after the last address.
- RD_ADDR (address driven, bus Z) -> RD_SAMPLE (compare sram_d with the expected pattern) -> next address.
- After the last RD_SAMPLE of the final pass -> DONE, with test_result=1.
- On the first mismatch -> DONE immediately, with test_result=0 (abort, no further accesses).
- DONE is absorbing until reset. In DONE: sram_we_n=1, bus Z, sram_a=0.
- Address counter is exactly ADDR_WIDTH bits. End of phase is detected on all-ones, not on wrap.

## Timing
- Reset values: sram_a=0, sram_we_n=1, sram_d=Z, test_in_progress=1, test_result=0, state=WR_SETUP, address=0.
- All outputs are registered from the state, address and pass registers. There are no combinational paths to the pins.
- Each write takes 3 cycles and each read takes 2, so a pass takes 5·2^ADDR_WIDTH cycles.
- Address and data are stable for one full cycle on both sides of the we_n low pulse.
- RD_SAMPLE samples one full cycle after the address is applied. The SRAM access time (≤15 ns) must be shorter than the clock period.
- test_in_progress falls on the edge that enters DONE. test_result is updated on that same edge.
- Reset mid-test: the engine aborts immediately and restarts from address 0, pass 0.

## Configuration
- RAMTEST_INVERSE_PASS_EN defined: two passes are run, P then ~P, so every cell is checked at both polarities. Total run is 10·2^ADDR_WIDTH cycles.
- Macro undefined: a single pass with P only.

## Structure
- Shared package ramtest_pkg holds:
  - the state enum (WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_SAMPLE, DONE);
  - the per-pass cycle constants (3 per write, 2 per read).
- Natural sub-module ramtest_pattern: a combinational function of address and pass bit that returns the expected byte. It is shared by the write and compare paths.

## Test plan
- Reset held low: sram_we_n=1, sram_d=Z, test_in_progress=1, test_result=0, sram_a=0.
- ADDR_WIDTH=4 with an ideal RAM model, released from reset: test_in_progress falls at edge 80 (160 with macro), and test_result=1.
- Same setup, RAM bit 2 stuck at 0 at address 5: test_result=0, and test_in_progress falls during the first read phase with no writes afterwards.
- RAM model that ignores address bit 3 (aliasing): the read of address 0 returns the data written for address 8, so the result is fail.
- Reset pulsed low mid-read phase: outputs return to their reset values and the full sequence re-runs, giving pass with an ideal RAM.
- Bus protocol check on every write: we_n is low for exactly 1 cycle, and sram_d/sram_a are stable in the cycles before, during and after it. sram_d is Z in every read state.
